mafia_mdu: RTL and testbench

- Iterative RV32M multiply/divide unit for the many-core RV32I core pipeline.
- Sits alongside the ALU in the execute stage, sized by the shared XLEN parameter.
- Accepts one operation via a valid/ready handshake and computes it over XLEN cycles with a shift-add or restoring-divide datapath.
- Returns the registered result to the writeback path via a valid/ready handshake.

---
 rtl/mafia_mdu.sv | 170 +++++++++++++++++
 tb/tb_mafia_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mafia_mdu.sv
// mafia_mdu: iterative RV32M multiply/divide unit for the execute stage.
// One operation is accepted per valid/ready handshake and computed over XLEN
// cycles (shift-add multiply, restoring divide). Divide-by-zero and signed
// overflow bypass the iteration and finish one cycle after acceptance.
//
// Ports:
//   Clk      in   core clock, rising edge
//   Rst      in   asynchronous active-high reset
//   ValidIn  in   upstream operation valid
//   ReadyOut out  unit can accept an operation (IDLE only)
//   Funct3   in   RV32M op select (MUL..REMU)
//   RegSrc1  in   rs1 operand (multiplicand / dividend)
//   RegSrc2  in   rs2 operand (multiplier / divisor)
//   ValidOut out  Result valid (DONE only)
//   ReadyIn  in   downstream accepts Result
//   Result   out  registered result
module mafia_mdu #(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            ValidIn,
    output logic            ReadyOut,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] RegSrc1,
    input  logic [XLEN-1:0] RegSrc2,
    output logic            ValidOut,
    input  logic            ReadyIn,
    output logic [XLEN-1:0] Result
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct_q, funct_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;

    // Operand conditioning at acceptance
    logic            s1_signed, s2_signed, neg1, neg2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    assign s1_signed = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                       (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign s2_signed = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                       (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign neg1 = s1_signed && RegSrc1[XLEN-1];
    assign neg2 = s2_signed && RegSrc2[XLEN-1];
    assign mag1 = neg1 ? -RegSrc1 : RegSrc1;
    assign mag2 = neg2 ? -RegSrc2 : RegSrc2;

    assign div_zero    = Funct3[2] && (RegSrc2 == '0);
    assign div_ovf     = Funct3[2] && !Funct3[0] && (RegSrc1 == MIN_NEG) && (RegSrc2 == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (Funct3[1] ? RegSrc1 : '1)
                                  : (Funct3[1] ? '0 : MIN_NEG);

    // One iteration. Multiply: acc = {partial product, remaining multiplier}.
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_tmp;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    assign div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge   = div_tmp >= {1'b0, opb_q};
    // Partial remainder stays below the divisor, so the XLEN-bit difference is exact.
    assign div_sub  = div_tmp[XLEN-1:0] - opb_q;
    assign div_next = {(div_ge ? div_sub : div_tmp[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    assign step   = funct_q[2] ? div_next : mul_next;
    assign prod_s = neg_res_q ? -step : step;
    assign quo    = step[XLEN-1:0];
    assign rem    = step[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        case (funct_q)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = neg_res_q ? -quo : quo;
            default:                final_res = neg_rem_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct_d   = funct_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        res_d     = res_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (ValidIn) begin
                    funct_d = Funct3;
                    if (special) begin
                        res_d   = special_res;
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_BUSY;
                        cnt_d     = CNT_W'(XLEN - 1);
                        neg_res_d = neg1 ^ neg2;
                        neg_rem_d = neg1;
                        acc_d     = Funct3[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
                        opb_d     = Funct3[2] ? mag2 : mag1;
                    end
                end
            end
            S_BUSY: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    res_d   = final_res;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (ReadyIn) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct_q   <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct_q   <= funct_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign ReadyOut = (state_q == S_IDLE);
    assign ValidOut = (state_q == S_DONE);
    assign Result   = res_q;

endmodule

// File: tb/tb_mafia_mdu.sv
// tb_mafia_mdu: randomized self-checking bench for mafia_mdu with a
// behavioural RV32M reference model and a scoreboard of accepted operations.
module tb_mafia_mdu;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ValidIn;
    logic        ReadyOut;
    logic [2:0]  Funct3;
    logic [31:0] RegSrc1;
    logic [31:0] RegSrc2;
    logic        ValidOut;
    logic        ReadyIn;
    logic [31:0] Result;

    mafia_mdu #(.XLEN(32)) dut (
        .Clk(Clk), .Rst(Rst), .ValidIn(ValidIn), .ReadyOut(ReadyOut),
        .Funct3(Funct3), .RegSrc1(RegSrc1), .RegSrc2(RegSrc2),
        .ValidOut(ValidOut), .ReadyIn(ReadyIn), .Result(Result)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    int n_issued = 0;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit and C-style integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int     q, r;
        if (!f[2]) begin
            sa = (f != 3'b011) ? longint'($signed(a)) : longint'({32'b0, a});
            sb = (f <= 3'b001) ? longint'($signed(b)) : longint'({32'b0, b});
            p  = sa * sb;
            return (f == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
        if (!f[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return f[1] ? r : q;
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
        return 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    // Compare process: scoreboard every handshake, check every DONE cycle.
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        logic hs;
        if (Rst) begin
            exp_q.delete();
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("readyout_after_hs", ReadyOut, 1);
            if (ValidOut) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", ValidOut, 0);
                end else begin
                    e = exp_q[0];
                    if (!prev_v) chk("latency", cyc - e.acc, e.lat);
                    chk("result", Result, e.res);
                    chk("readyout_in_done", ReadyOut, 0);
                end
            end else if (exp_q.size() != 0) begin
                chk("readyout_in_busy", ReadyOut, 0);
            end
            hs = ValidOut && ReadyIn;
            if (hs && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_done++;
            end
            if (ValidIn && ReadyOut) begin
                e.res = model(Funct3, RegSrc1, RegSrc2);
                e.acc = cyc + 1;
                e.lat = latency(Funct3, RegSrc1, RegSrc2);
                exp_q.push_back(e);
                n_acc++;
            end
            prev_v  = ValidOut && !hs;
            prev_hs = hs;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit keep);
        bit ok = 0;
        Funct3  = f;
        RegSrc1 = a;
        RegSrc2 = b;
        ValidIn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (ReadyOut) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge Clk);
        #1;
        n_issued++;
        if (!keep) ValidIn = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && ReadyOut) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    logic [2:0]  d_f[12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                             3'b101, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] d_a[12] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_r[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

    initial begin
        logic [31:0] r0;
        bit ok;
        Rst = 1'b1; ValidIn = 1'b0; ReadyIn = 1'b1;
        Funct3 = '0; RegSrc1 = '0; RegSrc2 = '0;
        #1;
        chk("reset_readyout", ReadyOut, 1);
        chk("reset_validout", ValidOut, 0);
        chk("reset_result", Result, 0);

        // Hand-computed values pin the reference model.
        for (int i = 0; i < 12; i++) chk($sformatf("model_pin%0d", i), model(d_f[i], d_a[i], d_b[i]), d_r[i]);
        chk("model_lat_divzero", latency(3'b100, 32'd5, 32'd0), 0);
        chk("model_lat_mulzero", latency(3'b000, 32'd0, 32'd0), 32);

        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b0;

        // Asynchronous reset aborts a MUL in cycle 10.
        issue(3'b000, 32'h0000_1234, 32'h0000_5678, 0);
        repeat (9) @(posedge Clk);
        #1 Rst = 1'b1;
        #1;
        chk("midop_rst_readyout", ReadyOut, 1);
        chk("midop_rst_validout", ValidOut, 0);
        chk("midop_rst_result", Result, 0);
        @(posedge Clk); #1 Rst = 1'b0;
        @(posedge Clk); #1;

        // Directed operations, including the single-cycle special cases.
        for (int i = 0; i < 12; i++) begin
            issue(d_f[i], d_a[i], d_b[i], 0);
            drain();
        end

        // Backpressure with ValidIn pulses during BUSY and DONE.
        ReadyIn = 1'b0;
        issue(3'b100, 32'd1000, 32'd7, 0);
        ValidIn = 1'b1;
        repeat (3) @(posedge Clk);
        #1 ValidIn = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (ValidOut) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("bp_valid_timeout", 0, 1);
        r0 = Result;
        chk("bp_result", r0, 32'd142);
        ValidIn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("bp_validout_held", ValidOut, 1);
            chk("bp_result_stable", Result, r0);
        end
        @(posedge Clk); #1;
        ValidIn = 1'b0;
        ReadyIn = 1'b1;
        drain();

        // Back-to-back random operations with ValidIn held high.
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < 100; i++)
                issue(3'(f), pick(), pick(), 1);
        ValidIn = 1'b0;
        drain();

        chk("accept_count", n_acc, n_issued);
        chk("done_count", n_done + 1, n_acc);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
